// File: rtl/time_set_ctrl_if.sv
// Pushbutton inputs, counter readback and edited-time outputs of the time-setting front end.
interface time_set_ctrl_if;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic [7:0] hours;
  logic [7:0] minutes;
  logic [7:0] seconds;
  logic [7:0] newHours;
  logic [7:0] newMinutes;
  logic [7:0] newSeconds;
  logic       load;
  logic [1:0] set_mode;
  logic       blink;

  modport slave (
    input  btn_mode, btn_up, btn_down, hours, minutes, seconds,
    output newHours, newMinutes, newSeconds, load, set_mode, blink
  );
  modport master (
    output btn_mode, btn_up, btn_down, hours, minutes, seconds,
    input  newHours, newMinutes, newSeconds, load, set_mode, blink
  );
endinterface

// File: rtl/time_set_ctrl.sv
// Time-setting front end: debounced mode/up/down buttons drive an edit FSM that
// snapshots the running time, edits H/M/S with wrap, and strobes load on exit.
module time_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int BLINK_CYCLES    = 25_000_000
) (
  input  logic           CLK100MHZ,
  input  logic           reset,
  time_set_ctrl_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BW = $clog2(BLINK_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BW-1:0] BL_LAST = BW'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } state_t;

  // Button bit order throughout: [0] mode, [1] up, [2] down
  logic [2:0]         w_raw;
  logic [2:0]         r_sync1, r_sync2;
  logic [2:0]         r_acc, r_acc_d;
  logic [2:0][DW-1:0] r_dcnt;
  logic [2:0]         w_evt;

  assign w_raw = {bus.btn_down, bus.btn_up, bus.btn_mode};

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_acc   <= '0;
      r_acc_d <= '0;
      r_dcnt  <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_acc_d <= r_acc;
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_acc[i]) begin
          r_dcnt[i] <= '0;
        end else if (r_dcnt[i] == DB_LAST) begin
          r_acc[i]  <= r_sync2[i];
          r_dcnt[i] <= '0;
        end else begin
          r_dcnt[i] <= r_dcnt[i] + DW'(1);
        end
      end
    end
  end

  // One pulse per accepted rising level; releases never generate events
  assign w_evt = r_acc & ~r_acc_d;

  logic w_up, w_dn;
  assign w_up = w_evt[1] & ~w_evt[2];
  assign w_dn = w_evt[2] & ~w_evt[1];

  function automatic logic [7:0] step(input logic [7:0] v, input logic [7:0] lim,
                                      input logic up, input logic dn);
    if (up) return (v == lim - 8'd1) ? 8'd0 : v + 8'd1;
    if (dn) return (v == 8'd0) ? lim - 8'd1 : v - 8'd1;
    return v;
  endfunction

  function automatic logic [7:0] clip(input logic [7:0] v, input logic [7:0] lim);
    return (v < lim) ? v : 8'd0;
  endfunction

  state_t     r_state, w_state_nxt;
  logic [7:0] r_h, r_m, r_s;
  logic [7:0] w_h_nxt, w_m_nxt, w_s_nxt;
  logic       r_load, w_load_nxt;
  logic [BW-1:0] r_bcnt;
  logic       r_blink;

  always_comb begin
    w_state_nxt = r_state;
    w_h_nxt     = r_h;
    w_m_nxt     = r_m;
    w_s_nxt     = r_s;
    w_load_nxt  = 1'b0;
    if (w_evt[0]) begin
      case (r_state)
        RUN: begin
          w_state_nxt = SET_H;
          w_h_nxt     = clip(bus.hours,   8'd24);
          w_m_nxt     = clip(bus.minutes, 8'd60);
          w_s_nxt     = clip(bus.seconds, 8'd60);
        end
        SET_H: w_state_nxt = SET_M;
        SET_M: w_state_nxt = SET_S;
        SET_S: begin
          w_state_nxt = RUN;
          w_load_nxt  = 1'b1;
        end
        default: w_state_nxt = RUN;
      endcase
    end else begin
      case (r_state)
        SET_H:   w_h_nxt = step(r_h, 8'd24, w_up, w_dn);
        SET_M:   w_m_nxt = step(r_m, 8'd60, w_up, w_dn);
        SET_S:   w_s_nxt = step(r_s, 8'd60, w_up, w_dn);
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_state <= RUN;
      r_h     <= '0;
      r_m     <= '0;
      r_s     <= '0;
      r_load  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_h     <= w_h_nxt;
      r_m     <= w_m_nxt;
      r_s     <= w_s_nxt;
      r_load  <= w_load_nxt;
    end
  end

  // Blink phase restarts high on every entry into editing
  always_ff @(posedge CLK100MHZ) begin
    if (reset || w_state_nxt == RUN) begin
      r_bcnt  <= '0;
      r_blink <= 1'b0;
    end else if (r_state == RUN) begin
      r_bcnt  <= '0;
      r_blink <= 1'b1;
    end else if (r_bcnt == BL_LAST) begin
      r_bcnt  <= '0;
      r_blink <= ~r_blink;
    end else begin
      r_bcnt  <= r_bcnt + BW'(1);
    end
  end

  assign bus.newHours   = r_h;
  assign bus.newMinutes = r_m;
  assign bus.newSeconds = r_s;
  assign bus.load       = r_load;
  assign bus.set_mode   = r_state;
  assign bus.blink      = r_blink;
endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed timing cases plus random button sequences
// checked against a transaction-level model of the edit behaviour.
module tb_time_set_ctrl;
  localparam int DEB = 4;
  localparam int BLK = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  time_set_ctrl_if bus();

  time_set_ctrl #(.DEBOUNCE_CYCLES(DEB), .BLINK_CYCLES(BLK)) dut (
    .CLK100MHZ(clk),
    .reset    (rst),
    .bus      (bus)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
  endtask

  // load monitor
  int n_load = 0;
  int n_dbl = 0;
  bit prev_load = 1'b0;
  int cap_h, cap_m, cap_s, cap_mode;
  always @(negedge clk) begin
    if (bus.load === 1'b1) begin
      n_load++;
      cap_h = bus.newHours; cap_m = bus.newMinutes; cap_s = bus.newSeconds;
      cap_mode = bus.set_mode;
      if (prev_load) n_dbl++;
    end
    prev_load = (bus.load === 1'b1);
  end

  // reference model: state 0..3, edited fields, expected load count
  int m_st = 0, m_h = 0, m_m = 0, m_s = 0, m_loads = 0;
  bit m_did_load;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_op(input bit md, input bit up, input bit dn);
    m_did_load = 1'b0;
    if (md) begin
      if (m_st == 0) begin
        m_h = (bus.hours   < 24) ? int'(bus.hours)   : 0;
        m_m = (bus.minutes < 60) ? int'(bus.minutes) : 0;
        m_s = (bus.seconds < 60) ? int'(bus.seconds) : 0;
        m_st = 1;
      end else if (m_st == 3) begin
        m_st = 0;
        m_loads++;
        m_did_load = 1'b1;
      end else m_st++;
    end else if (m_st != 0 && (up ^ dn)) begin
      int d;
      d = up ? 1 : -1;
      case (m_st)
        1: m_h = (m_h + d + 24) % 24;
        2: m_m = (m_m + d + 60) % 60;
        default: m_s = (m_s + d + 60) % 60;
      endcase
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".mode"}, bus.set_mode, m_st);
    chk({tag, ".h"}, bus.newHours, m_h);
    chk({tag, ".m"}, bus.newMinutes, m_m);
    chk({tag, ".s"}, bus.newSeconds, m_s);
    chk({tag, ".loads"}, n_load, m_loads);
    if (m_st == 0) chk({tag, ".blink_run"}, bus.blink, 0);
    if (m_did_load) begin
      chk({tag, ".ld_h"}, cap_h, m_h);
      chk({tag, ".ld_m"}, cap_m, m_m);
      chk({tag, ".ld_s"}, cap_s, m_s);
      chk({tag, ".ld_mode"}, cap_mode, 0);
    end
  endtask

  task automatic press(input bit md, input bit up, input bit dn);
    bus.btn_mode = md; bus.btn_up = up; bus.btn_down = dn;
    tick($urandom_range(DEB + 5, DEB));
    bus.btn_mode = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0;
    tick($urandom_range(DEB + 10, DEB + 5));
  endtask

  task automatic do_op(input string tag, input bit md, input bit up, input bit dn);
    press(md, up, dn);
    model_op(md, up, dn);
    check_model(tag);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    bus.hours = 8'(h); bus.minutes = 8'(m); bus.seconds = 8'(s);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got 0, want 1");
    $fatal(1, "timeout");
  end

  initial begin
    bus.btn_mode = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0;
    set_time(0, 0, 0);

    // reset state
    rst = 1'b1;
    tick(3);
    chk("rst.h", bus.newHours, 0);
    chk("rst.m", bus.newMinutes, 0);
    chk("rst.s", bus.newSeconds, 0);
    chk("rst.load", bus.load, 0);
    chk("rst.mode", bus.set_mode, 0);
    chk("rst.blink", bus.blink, 0);
    rst = 1'b0;
    bus.btn_up = 1'b1;
    tick(3);
    bus.btn_up = 1'b0;
    tick(12);
    check_model("up_glitch");

    // snapshot and full pass
    set_time(12, 34, 56);
    do_op("snap", 1, 0, 0);
    do_op("snap_up1", 0, 1, 0);
    do_op("snap_up2", 0, 1, 0);
    do_op("snap_m", 1, 0, 0);
    do_op("snap_dn", 0, 0, 1);
    do_op("snap_s", 1, 0, 0);
    do_op("snap_ld", 1, 0, 0);
    chk("pass.h", cap_h, 14);
    chk("pass.m", cap_m, 33);
    chk("pass.s", cap_s, 56);

    // wrap-around
    set_time(23, 59, 0);
    do_op("wrap", 1, 0, 0);
    do_op("wrap_h", 0, 1, 0);
    do_op("wrap_m", 1, 0, 0);
    do_op("wrap_mu", 0, 1, 0);
    do_op("wrap_s", 1, 0, 0);
    do_op("wrap_sd", 0, 0, 1);
    do_op("wrap_ld", 1, 0, 0);
    chk("wrap.h", cap_h, 0);
    chk("wrap.m", cap_m, 0);
    chk("wrap.s", cap_s, 59);

    // out-of-range snapshot and up/down cancellation
    set_time(30, 75, 10);
    do_op("oor", 1, 0, 0);
    chk("oor.h", bus.newHours, 0);
    chk("oor.m", bus.newMinutes, 0);
    do_op("oor_ud", 0, 1, 1);
    do_op("oor_m", 1, 0, 0);
    do_op("oor_s", 1, 0, 0);
    do_op("oor_ld", 1, 0, 0);

    // debounce: short glitch, then exact-latency 4-cycle hold
    set_time(7, 8, 9);
    bus.btn_mode = 1'b1;
    tick(3);
    bus.btn_mode = 1'b0;
    tick(12);
    chk("glitch.mode", bus.set_mode, 0);
    bus.btn_mode = 1'b1;
    tick(4);
    bus.btn_mode = 1'b0;
    tick(2);
    chk("lat.before", bus.set_mode, 0);
    tick(1);
    chk("lat.after", bus.set_mode, 1);
    model_op(1, 0, 0);
    for (int n = 0; n < 40; n++) begin
      chk("blink", bus.blink, ((n / BLK) % 2 == 0) ? 1 : 0);
      tick(1);
    end
    check_model("lat");
    bus.btn_mode = 1'b1;
    tick(100);
    bus.btn_mode = 1'b0;
    tick(15);
    model_op(1, 0, 0);
    check_model("hold100");

    // reset mid-edit (now in SET_M)
    do_op("mid_up", 0, 1, 0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mid.mode", bus.set_mode, 0);
    chk("mid.h", bus.newHours, 0);
    chk("mid.m", bus.newMinutes, 0);
    chk("mid.s", bus.newSeconds, 0);
    chk("mid.blink", bus.blink, 0);
    chk("mid.load", bus.load, 0);
    m_st = 0; m_h = 0; m_m = 0; m_s = 0;
    tick(20);
    check_model("mid_after");

    // random button sequences
    for (int i = 0; i < 80; i++) begin
      int r;
      set_time($urandom_range(99), $urandom_range(99), $urandom_range(99));
      r = $urandom_range(7);
      case (r)
        0, 1:    do_op("rnd_mode", 1, 0, 0);
        2, 3:    do_op("rnd_up", 0, 1, 0);
        4, 5:    do_op("rnd_dn", 0, 0, 1);
        6:       do_op("rnd_ud", 0, 1, 1);
        default: do_op("rnd_mu", 1, $urandom_range(1), $urandom_range(1));
      endcase
    end

    chk("no_double_load", n_dbl, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

User time-setting front end for the clock datapath: turns three raw pushbuttons (mode, up, down) into edited hours/minutes/seconds values and a one-cycle load strobe. It drives the newHours/newMinutes/newSeconds load inputs of counter_alu and reads back its hours/minutes/seconds outputs as the starting point for an edit. It also provides the set-mode and blink indications for the display path.

## Interface

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required to accept a button level change (10 ms at 100 MHz)
- BLINK_CYCLES, 25_000_000, half-period of the blink output, in cycles

Ports:
- CLK100MHZ  input  1  system clock, 100 MHz
- reset  input  1  synchronous, active-high reset
- btn_mode  input  1  raw mode button, asynchronous, active-high
- btn_up  input  1  raw increment button, asynchronous, active-high
- btn_down  input  1  raw decrement button, asynchronous, active-high
- hours  input  8  current hours from counter_alu, binary
- minutes  input  8  current minutes from counter_alu, binary
- seconds  input  8  current seconds from counter_alu, binary
- newHours  output  8  edited hours, binary, 0..23
- newMinutes  output  8  edited minutes, binary, 0..59
- newSeconds  output  8  edited seconds, binary, 0..59
- load  output  1  one-cycle strobe; new* are valid in this cycle
- set_mode  output  2  0 = RUN, 1 = SET_H, 2 = SET_M, 3 = SET_S
- blink  output  1  square wave while editing, 0 in RUN

## Operation

- Each button passes through a 2-flop synchronizer and then a debouncer. The debouncer counts consecutive cycles in which the synchronized level differs from the accepted level. At DEBOUNCE_CYCLES it flips the accepted level and clears the count. Any cycle that matches the accepted level clears the count.
- A press event is a single-cycle pulse on the accepted 0->1 transition. There is exactly one event per press: no auto-repeat, and no event on release.
- FSM states are RUN, SET_H, SET_M and SET_S. set_mode always equals the state encoding.
  - RUN + mode event: snapshot hours/minutes/seconds into the edit registers, then go to SET_H. Any snapshot field at or above its limit (24 for hours, 60 for minutes and seconds) is loaded as 0.
  - SET_H + mode event -> SET_M. SET_M + mode event -> SET_S.
  - SET_S + mode event: assert load for 1 cycle, then go to RUN.
- Editing in SET_x:
  - An up event increments the selected field modulo its range: 23->0 for hours, 59->0 for minutes and seconds.
  - A down event decrements with wrap: 0->23 for hours, 0->59 for minutes and seconds.
  - Other fields are unchanged.
- In RUN, up and down events are ignored and the edit registers hold.
- Priority within a cycle:
  - A mode event wins; up and down events in the same cycle are discarded.
  - Up and down events together cancel, so the field is unchanged.
- newHours/newMinutes/newSeconds continuously reflect the edit registers. Downstream logic must only consume them when load = 1.
- blink:
  - In any SET state, a counter toggles blink every BLINK_CYCLES cycles.
  - Entry into SET_H from RUN resets the counter and sets blink to 1.
  - In RUN, the counter is held at 0 and blink = 0.
- Reset values: state RUN, set_mode 0, edit registers 0 (so new* = 0), load 0, blink 0. Debounce counters are 0, accepted levels are 0, and synchronizers are cleared.
- Reset mid-edit abandons the edit: no load is issued, and the next cycle is RUN with all outputs at reset values.
- A button held through reset release produces a press event after a full debounce period. This is required behaviour, not a glitch.

## Timing

- Press latency: the raw button rises at edge k and is held. Sync output is high at k+2. The press event is high in cycle k+2+DEBOUNCE_CYCLES. The FSM and edit registers update on the following edge.
- The state change from a mode event is visible one cycle after the event.
- The load cycle coincides with set_mode changing 3->0. new* hold their values through the load cycle and after it.
- load is never high for two consecutive cycles. The minimum spacing between loads is a full mode cycle of four mode events.
- The snapshot samples hours/minutes/seconds in the event cycle, i.e. the edge on which the state changes from RUN to SET_H.
- Glitches shorter than DEBOUNCE_CYCLES produce no event.

## Test plan

Use DEBOUNCE_CYCLES = 4 and BLINK_CYCLES = 8 throughout.

- **Reset:** hold reset 3 cycles with buttons low -> new* = 0, load = 0, set_mode = 0, blink = 0. Pulse btn_up for 3 cycles -> no change in any output.
- **Snapshot and full pass:** apply hours = 12, minutes = 34, seconds = 56 and press mode once -> set_mode = 1, newHours = 12, blink = 1. Then apply up ×2 in SET_H, mode, down ×1 in SET_M, mode, then mode -> a single load pulse with new* = 14/33/56, and set_mode = 0 in the same cycle.
- **Wrap-around:** snapshot 23:59:00. One up in SET_H gives 0. In SET_M, one up gives 0. In SET_S, one down gives 59. The load shows 0/0/59.
- **Out-of-range snapshot and cancellation:** apply hours = 30 and minutes = 75 at the mode press -> newHours = 0, newMinutes = 0. Then make btn_up and btn_down stable in the same cycle -> field unchanged.
- **Debounce:** a 3-cycle high glitch on btn_mode gives no state change. A 4-cycle hold gives exactly one event, with set_mode changing at raw rise + 7 edges. Holding btn_mode for 100 cycles gives no second event.
- **Reset mid-edit:** in SET_M with edited values, assert reset for 1 cycle -> RUN next cycle, load never asserted, new* = 0, blink = 0.
